// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word load/store over a req/ready handshake,
// stall generation while memory is busy, timeout abort, and MEM/WB registers.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic        memWriteM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  writeRegM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stallM,
    output logic        memErr,
    output logic        regWriteW,
    output logic        memToRegW,
    output logic [31:0] readDataW,
    output logic [31:0] aluOutW,
    output logic [4:0]  writeRegW
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               access;
    logic               is_load;
    logic               done_rdy;
    logic               done_tmo;

    logic               rw_q;
    logic               mtr_q;
    logic [31:0]        rd_q;
    logic [31:0]        alu_q;
    logic [4:0]         wr_q;

    // A store wins when both load and store flags are set.
    assign access  = memToRegM | memWriteM;
    assign is_load = memToRegM & ~memWriteM;

    // Handshake outputs track the EX/MEM inputs; a reset cycle drops the request.
    assign dmem_req   = access & ~reset;
    assign dmem_we    = memWriteM;
    assign dmem_addr  = {aluOutM[31:2], 2'b00};
    assign dmem_wdata = writeDataM;

    // Hold upstream while the access has not completed this cycle.
    assign stallM = access & ~(done_rdy | done_tmo) & ~reset;

    // Next-state logic: wait counting and timeout abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_rdy = 1'b0;
        done_tmo = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (dmem_ready) begin
                        done_rdy = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!access) begin
                    // Upstream withdrew the access; nothing left to wait for.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (dmem_ready) begin
                    done_rdy = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    done_tmo = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // MEM/WB pipeline register; a stall inserts a bubble and holds data fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q  <= 1'b0;
            mtr_q <= 1'b0;
            rd_q  <= '0;
            alu_q <= '0;
            wr_q  <= '0;
        end else begin
            if (stallM) begin
                rw_q  <= 1'b0;
                mtr_q <= 1'b0;
            end else begin
                rw_q  <= regWriteM;
                mtr_q <= memToRegM;
                alu_q <= aluOutM;
                wr_q  <= writeRegM;
            end
            if (done_rdy && is_load) begin
                rd_q <= dmem_rdata;
            end else if (done_tmo && is_load) begin
                rd_q <= ERR_DATA;
            end
        end
    end

    assign memErr    = err_q;
    assign regWriteW = rw_q;
    assign memToRegW = mtr_q;
    assign readDataW = rd_q;
    assign aluOutW   = alu_q;
    assign writeRegW = wr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level model (each access completes after min(wait, timeout) stalls).
module tb_mem_access_stage;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWriteM, memToRegM, memWriteM;
    logic [31:0] aluOutM, writeDataM;
    logic [4:0]  writeRegM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stallM, memErr;
    logic        regWriteW, memToRegW;
    logic [31:0] readDataW, aluOutW;
    logic [4:0]  writeRegW;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stallM(stallM), .memErr(memErr),
        .regWriteW(regWriteW), .memToRegW(memToRegW), .readDataW(readDataW),
        .aluOutW(aluOutW), .writeRegW(writeRegW)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected MEM/WB contents and error flag
    logic        e_rw, e_mtr, e_err;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_w();
        check("regWriteW", 32'(regWriteW), 32'(e_rw));
        check("memToRegW", 32'(memToRegW), 32'(e_mtr));
        check("readDataW", readDataW, e_rd);
        check("aluOutW",   aluOutW,   e_alu);
        check("writeRegW", 32'(writeRegW), 32'(e_wr));
        check("memErr",    32'(memErr), 32'(e_err));
    endtask

    // Issue one instruction; memory raises ready on access cycle w (w > T never answers).
    task automatic run_instr(input logic rw, input logic mtr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] wr, input int w, input logic [31:0] rd);
        logic acc;
        logic ld;
        int   c;
        acc = mtr | mw;
        ld  = mtr & ~mw;
        c   = acc ? ((w <= T) ? w : T) : 0;
        regWriteM  = rw;
        memToRegM  = mtr;
        memWriteM  = mw;
        aluOutM    = alu;
        writeDataM = wd;
        writeRegM  = wr;
        for (int j = 0; j <= c; j++) begin
            if (acc) dmem_ready = (j == w);
            else     dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = (acc && j == w) ? rd : $urandom();
            @(negedge clk);
            check("stallM",   32'(stallM),   32'(acc && j < c));
            check("dmem_req", 32'(dmem_req), 32'(acc));
            if (acc) begin
                check("dmem_addr",  dmem_addr,  {alu[31:2], 2'b00});
                check("dmem_we",    32'(dmem_we), 32'(mw));
                check("dmem_wdata", dmem_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (j < c) begin
                e_rw  = 1'b0;
                e_mtr = 1'b0;
            end else begin
                e_rw  = rw;
                e_mtr = mtr;
                e_alu = alu;
                e_wr  = wr;
                if (ld) e_rd = (w <= T) ? rd : ERR;
                if (acc && w > T) e_err = 1'b1;
            end
            check_w();
        end
    endtask

    task automatic clear_inputs();
        regWriteM  = 1'b0;
        memToRegM  = 1'b0;
        memWriteM  = 1'b0;
        aluOutM    = '0;
        writeDataM = '0;
        writeRegM  = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
    endtask

    task automatic model_reset();
        e_rw  = 1'b0;
        e_mtr = 1'b0;
        e_err = 1'b0;
        e_rd  = '0;
        e_alu = '0;
        e_wr  = '0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        memToRegM = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("req_in_reset",   32'(dmem_req), 32'd0);
        check("stall_in_reset", 32'(stallM),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        check_w();

        // Zero-wait load
        run_instr(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd8, 0, 32'h1234_5678);
        // Store to unaligned address with three wait cycles
        run_instr(1'b0, 1'b0, 1'b1, 32'h203, 32'hCAFE_F00D, 5'd3, 3, 32'h0);
        // ALU-only stream
        for (int i = 0; i < 5; i++)
            run_instr(1'b1, 1'b0, 1'b0, $urandom(), $urandom(), 5'(i + 10), 0, 32'h0);
        // Load that never gets ready -> abort
        run_instr(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd9, T + 1, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd4, 0, 32'h0);
        // Back-to-back loads: one wait, then zero-wait
        run_instr(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd1, 1, 32'hAAAA_0001);
        run_instr(1'b1, 1'b1, 1'b0, 32'h504, 32'h0, 5'd2, 0, 32'hBBBB_0002);
        // Store with regWriteM set passes through unchanged; ready exactly at timeout
        run_instr(1'b1, 1'b0, 1'b1, 32'h608, 32'h1111_2222, 5'd7, T, 32'h0);
        run_instr(1'b1, 1'b1, 1'b0, 32'h60C, 32'h0, 5'd6, T, 32'h7777_8888);

        // Reset during the second wait cycle
        memToRegM  = 1'b1;
        regWriteM  = 1'b1;
        aluOutM    = 32'h700;
        writeRegM  = 5'd5;
        dmem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("req_mid_reset",   32'(dmem_req), 32'd0);
        check("stall_mid_reset", 32'(stallM),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        check_w();
        @(negedge clk);
        check("req_after_reset",   32'(dmem_req), 32'd0);
        check("stall_after_reset", 32'(stallM),   32'd0);
        @(posedge clk);
        #1;
        check_w();

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            int   kind;
            logic mtr, mw;
            kind = int'($urandom_range(0, 4));
            mtr  = (kind == 1) || (kind == 3) || (kind == 4);
            mw   = (kind == 2) || (kind == 4);
            run_instr(1'($urandom_range(0, 1)), mtr, mw, $urandom(), $urandom(),
                      5'($urandom_range(0, 31)), int'($urandom_range(0, T + 2)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
